// File: rtl/display_pkg.sv
`default_nettype none
// =============================================================================
// Module   : display_pkg
// Brief    : Shared types and active-low segment patterns for the display scanner.
// Revision : 1.0
// =============================================================================
package display_pkg;

    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Bit order {g,f,e,d,c,b,a}, a 0 lights the segment
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage
`default_nettype wire

// File: rtl/module_seg_decoder.sv
`default_nettype none
// =============================================================================
// Module   : module_seg_decoder
// Brief    : Combinational BCD nibble to active-low 7-segment pattern; >9 gives a dash.
// Revision : 1.0
// =============================================================================
module module_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        for (int i = 0; i < 10; i++) begin
            if (bcd_i == 4'(i)) begin
                seg_o = SEG_LUT[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/module_display_scan.sv
`default_nettype none
// =============================================================================
// Module   : module_display_scan
// Brief    : 4-digit multiplexed 7-segment scanner with dead-time, frame-aligned
//            load and leading-zero blanking. Option macro: SCAN_BLINK_EN (blink_i).
// Revision : 1.0
// =============================================================================
module module_display_scan
    import display_pkg::*;
#(
    parameter int CLK_HZ   = 27_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_i,
    input  logic        load_i,
    input  logic        blank_i,
`ifdef SCAN_BLINK_EN
    input  logic        blink_i,
`endif
    output logic        busy_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEAD_CYC + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

    logic [PW-1:0] presc_q;
    logic [DW-1:0] dead_q;
    logic [1:0]    idx_q;
    state_t        state_q;
    logic [15:0]   pend_q, pend_d;
    logic [15:0]   shown_q, shown_d;
    logic          busy_q, busy_d;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic          w_tick;
    logic          w_apply;
    logic [3:0]    w_digit;
    logic          w_dark;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg_on;

    assign w_tick  = (presc_q == PRESC_MAX);
    assign w_apply = w_tick && (idx_q == 2'd3) && busy_q;
    assign w_digit = shown_q[{idx_q, 2'b00} +: 4];
    // Digit is a leading zero when it and every higher digit are zero
    assign w_dark  = blank_i && (idx_q != 2'd0) && ((shown_q >> {idx_q, 2'b00}) == 16'h0000);

    module_seg_decoder u_dec (
        .bcd_i (w_digit),
        .seg_o (w_dec)
    );

`ifdef SCAN_BLINK_EN
    localparam int BLINK_PER = CLK_HZ / 2;
    localparam int BW        = $clog2(BLINK_PER);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_PER - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PER / 2);

    logic [BW-1:0] blink_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= (blink_q == BLINK_MAX) ? '0 : blink_q + 1'b1;
        end
    end

    assign w_seg_on = (w_dark || (blink_i && (blink_q >= BLINK_HALF))) ? SEG_BLANK : w_dec;
`else
    assign w_seg_on = w_dark ? SEG_BLANK : w_dec;
`endif

    // A load coinciding with the apply tick is kept pending; the old request is shown
    always_comb begin
        pend_d  = pend_q;
        shown_d = shown_q;
        busy_d  = busy_q;
        if (w_apply) begin
            shown_d = pend_q;
            busy_d  = 1'b0;
        end
        if (load_i) begin
            pend_d = digits_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= 16'h0000;
            shown_q <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            shown_q <= shown_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            dead_q  <= '0;
            idx_q   <= 2'd0;
            state_q <= ST_DEAD;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= w_tick ? '0 : presc_q + 1'b1;
            if (w_tick) begin
                idx_q   <= idx_q + 2'd1;
                state_q <= ST_DEAD;
                dead_q  <= '0;
            end else begin
                case (state_q)
                    ST_DEAD: begin
                        if (dead_q == DEAD_LAST) begin
                            state_q <= ST_ON;
                        end else begin
                            dead_q <= dead_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_ON;
                endcase
            end
            if (state_q == ST_ON) begin
                an_q  <= ~(4'b0001 << idx_q);
                seg_q <= w_seg_on;
            end else begin
                an_q  <= 4'hF;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign busy_o = busy_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_module_display_scan.sv
`default_nettype none
// =============================================================================
// Module   : tb_module_display_scan
// Brief    : Directed self-checking bench for module_display_scan (TICK_DIV=10, DEAD_CYC=2).
// Revision : 1.0
// =============================================================================
module tb_module_display_scan;

    logic        clk;
    logic        rst;
    logic [15:0] digits_i;
    logic        load_i;
    logic        blank_i;
`ifdef SCAN_BLINK_EN
    logic        blink_i;
`endif
    logic        busy_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;

    int checks = 0;
    int errors = 0;

    module_display_scan #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .DEAD_CYC (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digits_i (digits_i),
        .load_i   (load_i),
        .blank_i  (blank_i),
`ifdef SCAN_BLINK_EN
        .blink_i  (blink_i),
`endif
        .busy_o   (busy_o),
        .an_o     (an_o),
        .seg_o    (seg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      digits;
        logic             blank;
        logic [3:0][6:0]  seg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] d);
        digits_i = d;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    task automatic wait_apply();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 100);
        chk("apply_timeout", {15'd0, busy_o}, 16'd0);
    endtask

    // Called at the negedge just after the 3->0 wrap; returns at the next wrap
    task automatic check_frame(input logic [3:0][6:0] exp);
        for (int k = 0; k < 4; k++) begin
            step(2);
            chk("dead_an", {12'd0, an_o}, 16'h000F);
            chk("dead_seg", {9'd0, seg_o}, 16'h007F);
            step(1);
            chk("on_an_first", {12'd0, an_o}, {12'd0, ~(4'b0001 << k)});
            chk("on_seg_first", {9'd0, seg_o}, {9'd0, exp[k]});
            step(7);
            chk("on_an_last", {12'd0, an_o}, {12'd0, ~(4'b0001 << k)});
            chk("on_seg_last", {9'd0, seg_o}, {9'd0, exp[k]});
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h00AF, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h3F}};
        vecs[4] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h0908, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h00}};

        rst      = 1'b0;
        digits_i = 16'h0000;
        load_i   = 1'b0;
        blank_i  = 1'b0;
`ifdef SCAN_BLINK_EN
        blink_i  = 1'b0;
`endif

        step(3);
        chk("rst_an", {12'd0, an_o}, 16'h000F);
        chk("rst_seg", {9'd0, seg_o}, 16'h007F);
        chk("rst_busy", {15'd0, busy_o}, 16'd0);
        rst = 1'b1;
        step(1);
        chk("post_rst_an1", {12'd0, an_o}, 16'h000F);
        step(1);
        chk("post_rst_an2", {12'd0, an_o}, 16'h000F);
        chk("post_rst_seg2", {9'd0, seg_o}, 16'h007F);
        step(1);
        chk("first_on_an", {12'd0, an_o}, 16'h000E);
        chk("first_on_seg", {9'd0, seg_o}, 16'h0040);

        for (int v = 0; v < 6; v++) begin
            blank_i = vecs[v].blank;
            load(vecs[v].digits);
            chk("busy_after_load", {15'd0, busy_o}, 16'd1);
            wait_apply();
            check_frame(vecs[v].seg);
        end

        // Overwrite before apply: only the later request reaches the frame
        blank_i = 1'b0;
        step(12);
        load(16'h1111);
        chk("ovw_busy", {15'd0, busy_o}, 16'd1);
        step(9);
        load(16'h2222);
        step(16);
        chk("ovw_busy_pre_wrap", {15'd0, busy_o}, 16'd1);
        step(1);
        chk("ovw_busy_applied", {15'd0, busy_o}, 16'd0);
        step(3);
        chk("ovw_an", {12'd0, an_o}, 16'h000E);
        chk("ovw_seg", {9'd0, seg_o}, 16'h0024);

        // Load on the apply tick: old pending is shown, new one stays pending
        step(2);
        load(16'h3333);
        step(33);
        digits_i = 16'h4444;
        load_i   = 1'b1;
        step(1);
        load_i   = 1'b0;
        chk("coinc_busy", {15'd0, busy_o}, 16'd1);
        step(3);
        chk("coinc_seg_old", {9'd0, seg_o}, 16'h0030);
        step(36);
        chk("coinc_busy_held", {15'd0, busy_o}, 16'd1);
        step(1);
        chk("coinc_busy_clr", {15'd0, busy_o}, 16'd0);
        step(3);
        chk("coinc_an_new", {12'd0, an_o}, 16'h000E);
        chk("coinc_seg_new", {9'd0, seg_o}, 16'h0019);

        // Asynchronous reset during an ON phase with a request pending
        step(2);
        load(16'h5555);
        chk("mid_busy", {15'd0, busy_o}, 16'd1);
        chk("mid_an_on", {12'd0, an_o}, 16'h000E);
        rst = 1'b0;
        #1;
        chk("mid_rst_an", {12'd0, an_o}, 16'h000F);
        chk("mid_rst_seg", {9'd0, seg_o}, 16'h007F);
        chk("mid_rst_busy", {15'd0, busy_o}, 16'd0);
        step(2);
        rst = 1'b1;
        step(3);
        chk("rel_an", {12'd0, an_o}, 16'h000E);
        chk("rel_seg_cleared", {9'd0, seg_o}, 16'h0040);
        step(40);
        chk("rel_pend_lost_busy", {15'd0, busy_o}, 16'd0);
        chk("rel_pend_lost_seg", {9'd0, seg_o}, 16'h0040);

`ifdef SCAN_BLINK_EN
        begin
            int lit;
            load(16'h8888);
            wait_apply();
            blink_i = 1'b1;
            lit = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (seg_o != 7'h7F) lit++;
            end
            chk("blink_on_lit", 16'(lit), 16'd400);
            blink_i = 1'b0;
            step(2);
            lit = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (seg_o != 7'h7F) lit++;
            end
            chk("blink_off_lit", 16'(lit), 16'd800);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
